// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined ZBT frame-buffer port between the NTSC
// writer, the low-pass-filter reader and the VGA reader. Each request pulse is
// latched into a per-requester slot. One slot issues per cycle under a fixed
// priority (VGA > NTSC > LPF), and a starved LPF request is forced through.
// Read data comes back through a tag pipeline to the requester that asked for it.
//
// Handshake: every *_flag is a one-cycle request pulse with no back-pressure.
// A request is accepted when its slot is empty or is issuing in the same
// cycle. In any other case the request is dropped and the sticky overrun bit
// for that requester is set. Each accepted request gets exactly one done_*
// pulse, unless reset arrives before the pulse.
module mem_arbiter #(
  parameter int LOG_WIDTH  = 10,
  parameter int LOG_HEIGHT = 9,
  parameter int LOG_MEM    = 36,
  parameter int LOG_ADDR   = 19,
  parameter int RD_LATENCY = 2,
  parameter int WR_DELAY   = 2,
  parameter int STARVE     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_flag,
  input  logic                  ntsc_flag,
  input  logic [LOG_WIDTH-1:0]  ntsc_x,
  input  logic [LOG_HEIGHT-1:0] ntsc_y,
  input  logic [LOG_MEM-1:0]    ntsc_pixel_write,
  input  logic                  lpf_flag,
  input  logic [LOG_WIDTH-1:0]  lpf_x,
  input  logic [LOG_HEIGHT-1:0] lpf_y,
  input  logic                  vga_flag,
  input  logic [LOG_WIDTH-1:0]  vga_x,
  input  logic [LOG_HEIGHT-1:0] vga_y,
  output logic                  done_ntsc,
  output logic                  done_lpf,
  output logic                  done_vga,
  output logic [LOG_MEM-1:0]    lpf_pixel_read,
  output logic [LOG_MEM-1:0]    vga_pixel_read,
  output logic [LOG_ADDR-1:0]   mem_addr,
  output logic                  mem_we,
  output logic [LOG_MEM-1:0]    mem_din,
  input  logic [LOG_MEM-1:0]    mem_dout,
  output logic [2:0]            overrun
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_L = CW'(STARVE);

  logic                wbank;
  logic                n_v, l_v, v_v;
  logic [LOG_ADDR-1:0] n_a, l_a, v_a;
  logic [LOG_MEM-1:0]  n_d;
  logic [CW-1:0]       starve_cnt;
  logic                iss_n, iss_l, iss_v;

  // Tag pipeline (valid, id: 1 = VGA, 0 = LPF) and write-data pipeline
  logic [RD_LATENCY:0]             tag_v;
  logic [RD_LATENCY:0]             tag_id;
  logic [WR_DELAY-1:0]             wp_v;
  logic [WR_DELAY-1:0][LOG_MEM-1:0] wp_d;

  // x[0] only picks the pixel inside a word, so the memory never sees it
  logic unused_bits;
  assign unused_bits = ^{ntsc_x[0], lpf_x[0], vga_x[0]};

  // Pick at most one slot to issue; a starved LPF slot beats everyone
  always_comb begin
    iss_n = 1'b0;
    iss_l = 1'b0;
    iss_v = 1'b0;
    if (l_v && (starve_cnt >= STARVE_L)) iss_l = 1'b1;
    else if (v_v)                        iss_v = 1'b1;
    else if (n_v)                        iss_n = 1'b1;
    else if (l_v)                        iss_l = 1'b1;
  end

  // Bank toggle, request slots, overrun flags and the LPF starvation counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wbank      <= 1'b0;
      n_v        <= 1'b0;
      l_v        <= 1'b0;
      v_v        <= 1'b0;
      n_a        <= '0;
      l_a        <= '0;
      v_a        <= '0;
      n_d        <= '0;
      overrun    <= 3'b000;
      starve_cnt <= '0;
    end else begin
      if (frame_flag) wbank <= ~wbank;

      // Bank is captured at latch time, so a later toggle leaves pending slots alone
      if (ntsc_flag) begin
        if (!n_v || iss_n) begin
          n_v <= 1'b1;
          n_a <= {wbank, ntsc_y, ntsc_x[LOG_WIDTH-1:1]};
          n_d <= ntsc_pixel_write;
        end else begin
          overrun[0] <= 1'b1;
        end
      end else if (iss_n) begin
        n_v <= 1'b0;
      end

      if (lpf_flag) begin
        if (!l_v || iss_l) begin
          l_v <= 1'b1;
          l_a <= {~wbank, lpf_y, lpf_x[LOG_WIDTH-1:1]};
        end else begin
          overrun[1] <= 1'b1;
        end
      end else if (iss_l) begin
        l_v <= 1'b0;
      end

      if (vga_flag) begin
        if (!v_v || iss_v) begin
          v_v <= 1'b1;
          v_a <= {~wbank, vga_y, vga_x[LOG_WIDTH-1:1]};
        end else begin
          overrun[2] <= 1'b1;
        end
      end else if (iss_v) begin
        v_v <= 1'b0;
      end

      if (iss_l)                                  starve_cnt <= '0;
      else if (l_v && (starve_cnt != STARVE_L))   starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Drive the memory port and advance the read-tag and write-data pipelines
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_din   <= '0;
      done_ntsc <= 1'b0;
      tag_v     <= '0;
      tag_id    <= '0;
      wp_v      <= '0;
      wp_d      <= '0;
    end else begin
      mem_we    <= iss_n;
      done_ntsc <= iss_n;
      if (iss_v)      mem_addr <= v_a;
      else if (iss_n) mem_addr <= n_a;
      else if (iss_l) mem_addr <= l_a;

      tag_v[0]  <= iss_v | iss_l;
      tag_id[0] <= iss_v;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      wp_v[0] <= iss_n;
      wp_d[0] <= n_d;
      for (int i = 1; i < WR_DELAY; i++) begin
        wp_v[i] <= wp_v[i-1];
        wp_d[i] <= wp_d[i-1];
      end
      if (wp_v[WR_DELAY-1]) mem_din <= wp_d[WR_DELAY-1];
    end
  end

  // Capture returning read data for the requester named by the exiting tag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_lpf       <= 1'b0;
      done_vga       <= 1'b0;
      lpf_pixel_read <= '0;
      vga_pixel_read <= '0;
    end else begin
      done_lpf <= tag_v[RD_LATENCY] && !tag_id[RD_LATENCY];
      done_vga <= tag_v[RD_LATENCY] &&  tag_id[RD_LATENCY];
      if (tag_v[RD_LATENCY] && !tag_id[RD_LATENCY]) lpf_pixel_read <= mem_dout;
      if (tag_v[RD_LATENCY] &&  tag_id[RD_LATENCY]) vga_pixel_read <= mem_dout;
    end
  end

endmodule
